// File: rtl/trax_turn_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : trax_turn_ctrl
// Brief   : Trax turn sequencer between the transceiver and the board-update
//           and move-selection engines, with overrun and watchdog protection.
// Rev     : 1.0  initial release
// =============================================================================
module trax_turn_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter logic [21:0] OPEN_MOVE   = 22'h100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_done,
  input  logic [21:0] rx_move,
  input  logic        rx_color,
  output logic        upd_start,
  output logic [21:0] upd_move,
  input  logic        upd_done,
  output logic        sel_start,
  input  logic        sel_done,
  input  logic [21:0] sel_move,
  output logic        tx_start,
  output logic [21:0] tx_move,
  output logic        color,
  output logic [15:0] round,
  output logic        busy,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_RX   = 3'd1;
  localparam logic [2:0] S_APPLY_OPP = 3'd2;
  localparam logic [2:0] S_SELECT    = 3'd3;
  localparam logic [2:0] S_APPLY_OWN = 3'd4;
  localparam logic [2:0] S_SEND      = 3'd5;
  localparam logic [2:0] S_ERR       = 3'd6;

  localparam logic [1:0] E_NONE    = 2'b00;
  localparam logic [1:0] E_TIMEOUT = 2'b01;
  localparam logic [1:0] E_OVERRUN = 2'b10;
  localparam logic [1:0] E_DONE    = 2'b11;

  localparam int unsigned      WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [2:0]      r_state;
  logic [2:0]      w_state_nxt;
  logic            r_rx_prev;
  logic            r_pend;
  logic [21:0]     r_pend_move;
  logic [WD_W-1:0] r_wdog;
  logic            r_upd_start;
  logic            r_sel_start;
  logic            r_tx_start;
  logic [21:0]     r_upd_move;
  logic [21:0]     r_tx_move;
  logic            r_color;
  logic [15:0]     r_round;
  logic            r_err;
  logic [1:0]      r_err_code;

  logic            w_rx_edge;
  logic            w_watched;
  logic            w_busy;
  logic            w_done_err;
  logic            w_fault;
  logic [1:0]      w_fault_code;
  logic            w_upd_start_nxt;
  logic            w_sel_start_nxt;
  logic            w_tx_start_nxt;
  logic            w_start_any;

  assign w_rx_edge  = rx_done & ~r_rx_prev;
  assign w_watched  = (r_state == S_APPLY_OPP) || (r_state == S_SELECT) ||
                      (r_state == S_APPLY_OWN);
  assign w_busy     = w_watched || (r_state == S_SEND);
  assign w_done_err = (upd_done && (r_state != S_APPLY_OPP) && (r_state != S_APPLY_OWN)) ||
                      (sel_done && (r_state != S_SELECT)) ||
                      (upd_done && sel_done);
  assign w_start_any = w_upd_start_nxt | w_sel_start_nxt | w_tx_start_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_fault      = 1'b0;
    w_fault_code = E_NONE;
    // Fault priority: watchdog, engine protocol, receive overrun.
    if (r_state != S_ERR) begin
      if (w_watched && (r_wdog == WD_LAST)) begin
        w_fault      = 1'b1;
        w_fault_code = E_TIMEOUT;
      end else if (w_done_err) begin
        w_fault      = 1'b1;
        w_fault_code = E_DONE;
      end else if (w_busy && w_rx_edge && r_pend) begin
        w_fault      = 1'b1;
        w_fault_code = E_OVERRUN;
      end
    end
    case (r_state)
      S_IDLE:      if (w_rx_edge) w_state_nxt = rx_color ? S_WAIT_RX : S_APPLY_OWN;
      S_WAIT_RX:   if (r_pend || w_rx_edge) w_state_nxt = S_APPLY_OPP;
      S_APPLY_OPP: if (upd_done) w_state_nxt = S_SELECT;
      S_SELECT:    if (sel_done) w_state_nxt = S_APPLY_OWN;
      S_APPLY_OWN: if (upd_done) w_state_nxt = S_SEND;
      S_SEND:      w_state_nxt = S_WAIT_RX;
      S_ERR:       w_state_nxt = S_ERR;
      default:     w_state_nxt = S_IDLE;
    endcase
    if (w_fault) begin
      w_state_nxt = S_ERR;
    end
  end

  always_comb begin
    w_upd_start_nxt = 1'b0;
    w_sel_start_nxt = 1'b0;
    w_tx_start_nxt  = 1'b0;
    if (!w_fault) begin
      case (r_state)
        S_IDLE:      w_upd_start_nxt = w_rx_edge && !rx_color;
        S_WAIT_RX:   w_upd_start_nxt = r_pend || w_rx_edge;
        S_APPLY_OPP: w_sel_start_nxt = upd_done;
        S_SELECT:    w_upd_start_nxt = sel_done;
        S_APPLY_OWN: w_tx_start_nxt  = upd_done;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_prev   <= 1'b1;
      r_pend      <= 1'b0;
      r_pend_move <= '0;
      r_wdog      <= '0;
      r_upd_start <= 1'b0;
      r_sel_start <= 1'b0;
      r_tx_start  <= 1'b0;
      r_upd_move  <= '0;
      r_tx_move   <= '0;
      r_color     <= 1'b0;
      r_round     <= '0;
      r_err       <= 1'b0;
      r_err_code  <= E_NONE;
    end else begin
      r_rx_prev   <= rx_done;
      r_upd_start <= w_upd_start_nxt;
      r_sel_start <= w_sel_start_nxt;
      r_tx_start  <= w_tx_start_nxt;

      if (w_start_any || !w_watched) begin
        r_wdog <= '0;
      end else begin
        r_wdog <= r_wdog + WD_W'(1);
      end

      if (w_fault) begin
        r_err      <= 1'b1;
        r_err_code <= w_fault_code;
      end

      // WAIT_RX drains the pending slot; a fresh edge there refills it.
      if (r_state == S_WAIT_RX) begin
        if (w_rx_edge) r_pend_move <= rx_move;
        r_pend <= r_pend && w_rx_edge;
      end else if (w_busy && w_rx_edge && !r_pend) begin
        r_pend      <= 1'b1;
        r_pend_move <= rx_move;
      end

      if (w_upd_start_nxt) begin
        case (r_state)
          S_IDLE: begin
            r_upd_move <= OPEN_MOVE;
            r_tx_move  <= OPEN_MOVE;
          end
          S_WAIT_RX: r_upd_move <= r_pend ? r_pend_move : rx_move;
          default: begin
            r_upd_move <= sel_move;
            r_tx_move  <= sel_move;
          end
        endcase
      end

      if ((r_state == S_IDLE) && w_rx_edge && !w_fault) begin
        r_color <= rx_color;
      end

      if (w_tx_start_nxt && (r_round != 16'hFFFF)) begin
        r_round <= r_round + 16'd1;
      end
    end
  end

  assign upd_start = r_upd_start;
  assign sel_start = r_sel_start;
  assign tx_start  = r_tx_start;
  assign upd_move  = r_upd_move;
  assign tx_move   = r_tx_move;
  assign color     = r_color;
  assign round     = r_round;
  assign busy      = w_busy;
  assign err       = r_err;
  assign err_code  = r_err_code;

endmodule
`default_nettype wire

// File: doc/trax_turn_ctrl.md
TRAX_TURN_CTRL -- requirements
Module: trax_turn_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1000000, SHALL set the engine-handshake watchdog limit in clk cycles.
REQ-002 Parameter OPEN_MOVE, default 22'h100000 (tile plus, col 0, row 0), SHALL be the move sent when this side opens.
REQ-003 Ports SHALL be, as name direction width meaning:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- rx_done  in  1  transceiver receive-complete level; a 0->1 edge marks one received message
- rx_move  in  22  opponent move, {tile[21:20], col[19:10], row[9:0]}
- rx_color  in  1  our colour, 0 = white, 1 = black; valid at the first rx_done edge
- upd_start  out  1  one-cycle pulse; board-update engine applies upd_move
- upd_move  out  22  move to apply
- upd_done  in  1  one-cycle pulse; board update and auto-complete finished
- sel_start  out  1  one-cycle pulse; move-selection engine starts
- sel_done  in  1  one-cycle pulse; sel_move valid
- sel_move  in  22  chosen move
- tx_start  out  1  one-cycle pulse; transceiver sends tx_move
- tx_move  out  22  move to transmit, held stable until the next tx_start
- color  out  1  latched colour
- round  out  16  completed own moves, saturates at 16'hFFFF
- busy  out  1  high in every state except IDLE, WAIT_RX and ERR
- err  out  1  sticky fault flag
- err_code  out  2  01 = watchdog timeout, 10 = rx overrun, 11 = engine done without start

Function
REQ-004 States SHALL be IDLE, WAIT_RX, APPLY_OPP, SELECT, APPLY_OWN, SEND and ERR.
REQ-005 Edge detection SHALL use a previous-value register reset to 1, so rx_done held high through reset is not counted.
REQ-006 In IDLE, the first rx_done edge SHALL latch rx_color into color and ignore rx_move.
- If white: upd_move = OPEN_MOVE, pulse upd_start, go to APPLY_OWN.
- If black: go to WAIT_RX.
REQ-007 In WAIT_RX, an rx_done edge SHALL set upd_move = rx_move, pulse upd_start the next cycle, and go to APPLY_OPP.
REQ-008 In APPLY_OPP, upd_done SHALL pulse sel_start the next cycle and move to SELECT.
REQ-009 In SELECT, sel_done SHALL capture sel_move into upd_move and tx_move, pulse upd_start the next cycle, and move to APPLY_OWN.
REQ-010 On entry to APPLY_OWN from IDLE, tx_move SHALL be loaded with OPEN_MOVE.
REQ-011 In APPLY_OWN, upd_done SHALL pulse tx_start the next cycle, increment round, and move to SEND.
REQ-012 SEND SHALL last exactly one cycle, then go to WAIT_RX.
REQ-013 Latency from the accepted rx_done edge to upd_start SHALL be 1 cycle; from upd_done or sel_done to the following start pulse, 1 cycle.
REQ-014 A rx_done edge while busy SHALL set a one-deep pending flag holding rx_move; WAIT_RX consumes the pending entry first, with the same 1-cycle latency.
REQ-015 A second edge while pending is set SHALL go to ERR with err_code 10.
REQ-016 A watchdog counter SHALL clear on each start pulse and count while in APPLY_OPP, SELECT or APPLY_OWN; reaching TIMEOUT_CYC SHALL go to ERR with err_code 01.
REQ-017 upd_done outside APPLY_OPP/APPLY_OWN, or sel_done outside SELECT, SHALL go to ERR with err_code 11; simultaneous upd_done and sel_done SHALL also go to ERR with err_code 11.
REQ-018 ERR SHALL be terminal until reset, with all start pulses suppressed and err = 1.
REQ-019 At most one of upd_start, sel_start and tx_start SHALL be high in any cycle.

Reset
REQ-020 reset SHALL take priority over all other inputs.
REQ-021 While reset is high, including mid-operation, the block SHALL go to IDLE with:
- all start pulses 0
- upd_move and tx_move 0
- color, round, busy, err and err_code 0
- pending, the watchdog counter and the edge register cleared (edge register to 1).

Verification
REQ-022 White opening: color edge with rx_color = 0 -> upd_start with upd_move = 22'h100000; upd_done -> tx_start next cycle, tx_move = 22'h100000, round = 1.
REQ-023 Black turn: color edge with rx_color = 1, then rx_done with rx_move = 22'h200401 -> upd_move = 22'h200401; upd_done -> sel_start; sel_move = 22'h300002 -> upd_start, then tx_start with tx_move = 22'h300002.
REQ-024 Pending: rx edge arrives during SELECT -> no error; after tx_start, the stored move is applied one cycle after WAIT_RX entry.
REQ-025 Overrun: two rx edges during APPLY_OPP -> err = 1, err_code = 10, no further start pulses.
REQ-026 Timeout: TIMEOUT_CYC = 16 with sel_done withheld -> ERR on the 16th SELECT cycle, err_code = 01.
REQ-027 Reset mid-SELECT -> all outputs at reset values the next cycle; a new colour edge restarts from IDLE.
